// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// ib_entry_t is one fetched instruction with its branch-prediction context.
package inst_buffer_pkg;

   localparam int IB_SZ    = 16;
   localparam int IB_CNT_W = $clog2(IB_SZ + 1);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        predict_taken;
      logic [31:0] predict_target;
   } ib_entry_t;

   localparam int IB_ENTRY_W = $bits(ib_entry_t);

endpackage

// File: rtl/ib_compact.sv
// Combinational lane compaction: prefix popcount of the fetch valid mask gives each
// lane its write offset from tail, plus the total number of lanes being pushed.
module ib_compact #(
   parameter int N     = 3,
   parameter int OFF_W = $clog2(N + 1)
) (
   input  logic [N-1:0]       i_valid,
   output logic [N*OFF_W-1:0] o_offset,
   output logic [OFF_W-1:0]   o_push_cnt
);

   logic [OFF_W-1:0] w_acc;

   always_comb begin
      w_acc    = '0;
      o_offset = '0;
      for (int i = 0; i < N; i++) begin
         o_offset[i*OFF_W +: OFF_W] = w_acc;
         w_acc = w_acc + OFF_W'(i_valid[i]);
      end
      o_push_cnt = w_acc;
   end

endmodule

// File: rtl/inst_buffer.sv
// N-wide circular instruction buffer; outputs are combinational from state (no bypass).
// Fetch is throttled by almost_full; pop is all-or-nothing and blocked by stall.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int N     = 3,
   parameter int DEPTH = IB_SZ,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [N-1:0]            i_if_valid,
   input  logic [N*IB_ENTRY_W-1:0] i_if_entries,
   input  logic                    i_stall,
   input  logic                    i_squash,
   output logic                    o_almost_full,
   output logic [N-1:0]            o_id_valid,
   output logic [N*IB_ENTRY_W-1:0] o_id_entries,
   output logic [CNT_W-1:0]        o_counter_out
);

   localparam int OFF_W = $clog2(N + 1);

   ib_entry_t        r_entries [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [N*OFF_W-1:0] w_offset;
   logic [OFF_W-1:0]   w_push_cnt;
   logic               w_push_ok;
   logic [CNT_W-1:0]   w_push_amt;
   logic [CNT_W-1:0]   w_pop_cnt;

   ib_compact #(.N(N), .OFF_W(OFF_W)) u_compact (
      .i_valid    (i_if_valid),
      .o_offset   (w_offset),
      .o_push_cnt (w_push_cnt)
   );

   // Uses registered count only, so a same-cycle pop never opens space for fetch.
   assign o_almost_full = (CNT_W'(DEPTH) - r_count) < CNT_W'(N);
   assign w_push_ok     = ~o_almost_full & ~i_squash;
   assign w_push_amt    = w_push_ok ? CNT_W'(w_push_cnt) : '0;
   assign w_pop_cnt     = i_stall ? '0 : ((r_count < CNT_W'(N)) ? r_count : CNT_W'(N));
   assign o_counter_out = r_count;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_pop_cnt);
         r_tail  <= r_tail + PTR_W'(w_push_amt);
         r_count <= r_count + w_push_amt - w_pop_cnt;
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push_ok) begin
         for (int i = 0; i < N; i++) begin
            if (i_if_valid[i]) begin
               r_entries[r_tail + PTR_W'(w_offset[i*OFF_W +: OFF_W])] <=
                  ib_entry_t'(i_if_entries[i*IB_ENTRY_W +: IB_ENTRY_W]);
            end
         end
      end
   end

   always_comb begin
      o_id_entries = '0;
      o_id_valid   = '0;
      for (int i = 0; i < N; i++) begin
         o_id_entries[i*IB_ENTRY_W +: IB_ENTRY_W] = r_entries[r_head + PTR_W'(i)];
         o_id_valid[i] = CNT_W'(i) < r_count;
      end
   end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- N-wide circular FIFO between fetch and decode/dispatch.
- Decouples the fetch bundle rate from the out-of-order core's dispatch acceptance.
- Holds fetched instructions and presents up to N oldest in program order to decode.
- Pop is blocked while the core raises structural_hazard; contents are discarded on squash.

Parameters:
- N, `N, superscalar width (lanes per bundle).
- DEPTH, 16, entry count; must be ≥ 2*N and a power of two.
- PTR_W, $clog2(DEPTH), head/tail pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low; state clears while reset==0.
- if_valid  in  N  per-lane enqueue valid from fetch.
- if_entries  in  N x IB_ENTRY  fetched insn bundle: inst, PC, NPC, predict_taken, predict_target.
- stall  in  1  structural_hazard from the core; when 1, no pop.
- squash  in  1  branch-mispredict flush from commit.
- almost_full  out  1  free slots < N; fetch must not present valid lanes while set.
- id_valid  out  N  per-lane valid to decode.
- id_entries  out  N x IB_ENTRY  N oldest entries, lane 0 oldest.
- counter_out  out  CNT_W  occupancy (debug).

Behaviour:
- Reset (reset==0, async): head=0, tail=0, count=0, all entry valid bits 0.
  - Resulting outputs: almost_full=0, id_valid=0, counter_out=0.
- Storage:
  - DEPTH entries; head points at the oldest, tail at the next free slot.
  - Pointers wrap modulo DEPTH; wrap-around is a natural PTR_W overflow.
- Output (combinational from state, zero latency):
  - lane i presents entries[(head+i) mod DEPTH].
  - id_valid[i] = (i < count).
- Pop:
  - pop_cnt = stall ? 0 : min(count, N).
  - head += pop_cnt at the clock edge.
  - Decode consumes every valid lane presented in a non-stall cycle; there is no partial acceptance.
- Push:
  - push_cnt = popcount(if_valid).
  - Valid lanes are compacted in lane order into slots tail, tail+1, ...; tail += push_cnt.
  - Push is honoured only when almost_full==0 in that cycle; if fetch violates this, all lanes are dropped (no partial write).
- Count: count_next = count + push_cnt - pop_cnt, CNT_W wide.
  - Never exceeds DEPTH: the almost_full gate guarantees this.
  - Never negative: pop is bounded by count.
- almost_full = (DEPTH - count) < N, computed from the registered count.
  - Conservative: ignores a same-cycle pop.
- Simultaneous push and pop: both apply in one edge.
  - A pushed entry is not visible on id_* until the next cycle, even if count was 0 (no bypass).
- squash has priority over push and pop.
  - Next edge: head=tail=0, count=0, all valid bits cleared.
  - Same-cycle push is discarded.
  - Same-cycle id_* outputs are still driven; the core ignores them because its own squash blocks dispatch.
- Empty with stall=0: id_valid=0; no pointer movement.
- Full (count==DEPTH): almost_full=1; pop proceeds normally when stall=0.
- No state machine beyond the head/tail/count registers.
- stall must not gate push.

Decomposition:
- Shared package (sys_defs.svh):
  - IB_ENTRY struct: inst, PC, NPC, predict_taken, predict_target.
  - `IB_SZ (DEPTH default 16).
  - `IB_CNT_WIDTH.
- Sub-module: one natural sub-module, ib_compact (combinational).
  - Maps the N-lane if_valid mask to a per-lane write offset (prefix popcount) and a total push_cnt.
  - Reused by the pointer and write logic.
- Everything else stays in inst_buffer.

Test Plan (N=3, DEPTH=8):
- Reset held low mid-stream with count=5, then released → counter_out=0, id_valid=000, almost_full=0 immediately during reset (async) and after release.
- Push 3 insns PC=0x0,0x4,0x8, stall=0 → next cycle id_valid=111, lanes PC 0x0/0x4/0x8, counter_out=3; following cycle counter_out=0.
- Push if_valid=101 (PC 0x10, 0x18) → stored contiguously; next cycle id_valid=011, lane0 PC=0x10, lane1 PC=0x18.
- Hold stall=1 while pushing 3 bundles of 3 → counter_out=6, almost_full=1 (free 2<3); a fourth push with valid=111 while almost_full → dropped, counter stays 6; release stall → drains 3/cycle in PC order.
- Pre-fill so head=6, then push and pop across the wrap → outputs stay in PC order; pointers return to 0–1 correctly; counter consistent.
- count=5, squash=1 with simultaneous valid push and stall=0 → next cycle counter_out=0, id_valid=000, pushed insns absent.
